pbd_scan: RTL

- Parametrised, clocked successor to the 1-to-2 enable decoder: a binary-to-one-hot decoder of 2**SEL_W outputs with a registered enable.
- Two modes. Direct mode decodes an external select. Scan mode walks an internal pointer through every output with a programmable dwell and an optional blanking cycle between slots.
- Drives strobes and row selects, e.g. multiplexed display digits and bank enables, from a single clock domain.

---
 rtl/pbd_pkg.sv | 30 +++
 rtl/pbd_scan_onehot_dec.sv | 20 ++
 rtl/pbd_scan.sv | 96 +++++++++
 3 files changed

// File: rtl/pbd_pkg.sv
// Shared constants and helpers for the scanned one-hot decoder.
package pbd_pkg;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_N     = 1 << MAX_SEL_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Scan phase: showing the current slot, or the break-before-make gap.
  typedef enum logic {
    PH_SHOW  = 1'b0,
    PH_BLANK = 1'b1
  } phase_e;

  // One-hot of idx at the widest supported size; callers truncate.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Map an active-high vector to the output polarity.
  function automatic logic [MAX_N-1:0] apply_pol(input logic [MAX_N-1:0] v,
                                                 input logic act_low);
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/pbd_scan_onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable (active-high result).
module onehot_dec
  import pbd_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    en_i,
  output logic [(1<<SEL_W)-1:0]   y_o_c
);

  localparam int unsigned N = 1 << SEL_W;

  // All zeros when disabled, otherwise exactly one bit set.
  always_comb begin
    y_o_c = '0;
    if (en_i) y_o_c = N'(onehot(MAX_SEL_W'(sel_i)));
  end

endmodule

// File: rtl/pbd_scan.sv
// Clocked one-hot decoder with direct select or a self-timed scan pointer.
module pbd_scan
  import pbd_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4,
  parameter bit          ACT_LOW = 1'b0,
  parameter bit          BLANK   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        cur,
  output logic                    wrap
);

  localparam int unsigned N = 1 << SEL_W;
  localparam logic [N-1:0] Y_IDLE = ACT_LOW ? {N{1'b1}} : {N{1'b0}};

  phase_e             ph_q, ph_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       y_q, y_d;
  logic               show_d;
  logic [N-1:0]       dec_c;

  // Decode the next pointer value; blanked or disabled cycles decode to zero.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel_i (cur_d),
    .en_i  (show_d),
    .y_o_c (dec_c)
  );

  // Output polarity applied before the y register.
  always_comb y_d = N'(apply_pol(MAX_N'(dec_c), ACT_LOW));

  // Next pointer/counter/phase; blank cycles do not consume dwell.
  always_comb begin
    ph_d   = ph_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    show_d = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        cur_d  = sel;
        cnt_d  = '0;
        ph_d   = PH_SHOW;
        show_d = 1'b1;
      end else if (ph_q == PH_BLANK) begin
        ph_d   = PH_SHOW;
        show_d = 1'b1;
      end else if (cnt_q >= dwell) begin
        cnt_d  = '0;
        cur_d  = cur_q + SEL_W'(1);
        wrap_d = (cur_q == {SEL_W{1'b1}});
        if (BLANK) begin
          ph_d   = PH_BLANK;
          show_d = 1'b0;
        end else begin
          show_d = 1'b1;
        end
      end else begin
        cnt_d  = cnt_q + DWELL_W'(1);
        show_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= PH_SHOW;
      cur_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      y_q    <= Y_IDLE;
    end else begin
      ph_q   <= ph_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      y_q    <= y_d;
    end
  end

  assign y    = y_q;
  assign cur  = cur_q;
  assign wrap = wrap_q;

endmodule
